conv2d_stream: RTL and testbench
================================

# conv2d_stream

Streaming single-channel 2-D convolution engine for the quantised CNN datapath. It is the parametrised successor of the fixed 3x3 conv unit. Pixels arrive in raster order on a valid/ready handshake. A K-row line buffer inside the block supplies the windows, and zero padding, arbitrary stride and signed saturation are handled internally. Each result is a bias-added, shifted, optionally ReLU'd N-bit activation, and the block sits between the input feature-map buffer and the pooling stage.

## Interface
- N, 8: signed data/weight width
- INPUT_SIZE, 28: input feature map is INPUT_SIZE x INPUT_SIZE
- KERNEL_SIZE, 3: kernel is K x K
- STRIDE, 1: window step in both axes, >=1
- PADDING, 0: zero rows/cols added on each side
- ACC_W, 32: accumulator width
- Derived: W = INPUT_SIZE+2*PADDING; OUT_SIZE = (W-K)/STRIDE+1
- clk  in  1  clock; one clock domain, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: latch weight_din, bias_din, shift_din, relu_en; begin a frame
- din_vld  in  1  input pixel valid
- din  in  N  signed input pixel
- din_rdy  out  1  block accepts din this cycle
- weight_din  in  K*K*N  kernel; element (ky,kx) at [N*(K*K-1-(ky*K+kx)) +: N] (first element in MSBs)
- bias_din  in  ACC_W  signed bias
- shift_din  in  5  arithmetic right-shift amount
- relu_en  in  1  1 = clamp negatives to 0
- dout  out  N  signed result
- dout_vld  out  1  dout valid, one-cycle per result
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last result

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: busy=0, din_rdy=0. On start, latch configuration, clear line buffer, window and scan counters (row r, col c over the padded W x W grid), and move to RUN.
- RUN: the scan advances one padded position per step.
  - Pad position (r or c outside [PADDING, PADDING+INPUT_SIZE-1]): zero is inserted, din_rdy=0, the scan advances unconditionally.
  - Real position: din_rdy=1; the scan advances only when din_vld=1.
  - After position (W-1, W-1) is consumed, move to FLUSH.
- Window emit: when the consumed position satisfies r>=K-1, c>=K-1, (r-K+1)%STRIDE==0 and (c-K+1)%STRIDE==0, the current KxK window enters the pipeline. There are exactly OUT_SIZE^2 emits per frame, in raster order.
- FLUSH: lasts 3 cycles to drain the pipeline. On the last FLUSH cycle frame_done=1, then the block returns to IDLE.
- Arithmetic:
  - Products are signed 2N bits, summed into signed ACC_W, then bias is added.
  - Arithmetic right shift by shift_din (floor).
  - If relu_en and the value is negative, the result is 0.
  - Saturate to [-2^(N-1), 2^(N-1)-1].
- Boundary conditions:
  - start while busy=1 is ignored.
  - din_vld while din_rdy=0 is ignored; the pixel is not consumed.
  - Gaps in din_vld stall the scan; no state is lost.
  - Reset mid-frame aborts immediately: state IDLE, pipeline empty, no frame_done.

## Timing
- Reset values: dout=0, dout_vld=0, din_rdy=0, busy=0, frame_done=0, state IDLE.
- start in cycle t gives busy=1 from t+1; din_rdy may be 1 from t+1 if PADDING=0.
- din_rdy depends only on state and counters, never combinationally on din_vld.
- Throughput: one padded position per cycle when din_vld is held high.
- Latency: dout_vld rises 3 cycles after the cycle that consumes the window's last position. Pipeline stages are products, adder tree + bias, shift/ReLU/saturate.
- With din_vld held high, a frame takes W*W cycles in RUN plus 3 in FLUSH. frame_done coincides with or follows the final dout_vld.
- busy drops the cycle after frame_done.

## Test plan
- K=3, S=1, P=0, INPUT_SIZE=6; all pixels 1, all weights 1, bias 0, shift 0, din_vld held high -> 16 dout_vld pulses, each dout=9; frame_done 3 cycles after the 36th accept.
- P=1, INPUT_SIZE=4, identity kernel (centre weight 1, others 0), pixels 1..16 -> 16 outputs equal to 1..16 in order; din_rdy low for the first 7 cycles of RUN (top pad row + left pad column).
- S=2, INPUT_SIZE=6, P=0, pixel value = raster index, weights all 1 -> exactly 4 outputs, windows anchored at (0,0), (0,2), (2,0), (2,2).
- Saturation and ReLU (3x3, all pixels 127):
  - weights 127 -> dout=127;
  - weights -1, relu_en=0 -> -1143 saturates to -128;
  - weights -1, relu_en=1 -> 0.
- Bias and shift (all-ones window, sum 9):
  - bias 5, shift 2 -> 3;
  - bias -18, shift 2 -> -3 (floor).
- Robustness:
  - random din_vld gaps -> outputs identical to the gap-free run;
  - start pulsed mid-frame -> ignored;
  - rst_n low mid-frame -> all outputs 0 asynchronously; a fresh start then yields a full correct frame.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming single-channel KxK convolution over a raster pixel
// stream with internal zero padding, stride, bias, arithmetic shift, optional
// ReLU and signed saturation. Arithmetic runs in a fixed 3-stage pipeline.
module conv2d_stream #(
  parameter int N           = 8,
  parameter int INPUT_SIZE  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 0,
  parameter int ACC_W       = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    din_vld,
  input  logic [N-1:0]                            din,
  output logic                                    din_rdy,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*N-1:0]    weight_din,
  input  logic [ACC_W-1:0]                        bias_din,
  input  logic [4:0]                              shift_din,
  input  logic                                    relu_en,
  output logic [N-1:0]                            dout,
  output logic                                    dout_vld,
  output logic                                    busy,
  output logic                                    frame_done
);

  localparam int K   = KERNEL_SIZE;
  localparam int KK  = K * K;
  localparam int W   = INPUT_SIZE + 2 * PADDING;
  localparam int LBR = (K > 1) ? K - 1 : 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PW = 2 * N;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (N - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Control and configuration
  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic [1:0]              fl_q, fl_d;
  logic [KK*N-1:0]         w_q, w_d;
  logic signed [ACC_W-1:0] bias_q, bias_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic                    din_rdy_q, din_rdy_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;

  logic                    consume;
  logic                    clear;
  logic                    emit;
  logic signed [N-1:0]     pix;

  // Line buffer (previous K-1 rows per column) and sliding window
  logic signed [N-1:0]     lb_q  [LBR][W];
  logic signed [N-1:0]     lb_d  [LBR][W];
  logic signed [N-1:0]     win_q [K][K];
  logic signed [N-1:0]     win_d [K][K];
  logic signed [N-1:0]     newcol [K];

  // Arithmetic pipeline
  logic                    p_vld_q, p_vld_d;
  logic signed [PW-1:0]    prod_q [KK];
  logic signed [PW-1:0]    prod_d [KK];
  logic                    s_vld_q, s_vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sh;
  logic [N-1:0]            dout_q, dout_d;
  logic                    dout_vld_q, dout_vld_d;

  function automatic logic real_pos(input logic [CW-1:0] p);
    return (int'(p) >= PADDING) && (int'(p) < PADDING + INPUT_SIZE);
  endfunction

  // Scan FSM: walks the padded grid, inserting zeros at pad positions
  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    c_d          = c_q;
    fl_d         = fl_q;
    w_d          = w_q;
    bias_d       = bias_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    frame_done_d = 1'b0;
    consume      = 1'b0;
    clear        = 1'b0;
    pix          = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          w_d     = weight_din;
          bias_d  = bias_din;
          shift_d = shift_din;
          relu_d  = relu_en;
          r_d     = '0;
          c_d     = '0;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        consume = din_rdy_q ? din_vld : 1'b1;
        pix     = din_rdy_q ? din : '0;
        if (consume) begin
          if (c_q == CW'(W - 1)) begin
            c_d = '0;
            if (r_q == CW'(W - 1)) begin
              state_d = S_FLUSH;
              fl_d    = '0;
            end else begin
              r_d = r_q + CW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        fl_d         = fl_q + 2'd1;
        frame_done_d = (fl_q == 2'd1);
        if (fl_q == 2'd2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d != S_IDLE);
    din_rdy_d = (state_d == S_RUN) && real_pos(r_d) && real_pos(c_d);
  end

  // A window is emitted when the consumed position completes a strided KxK block
  assign emit = consume
             && (int'(r_q) >= K - 1) && (int'(c_q) >= K - 1)
             && (((int'(r_q) - (K - 1)) % STRIDE) == 0)
             && (((int'(c_q) - (K - 1)) % STRIDE) == 0);

  // Line buffer column shift and window slide on every consumed position
  always_comb begin
    lb_d  = lb_q;
    win_d = win_q;
    for (int k = 0; k < K; k++) newcol[k] = pix;
    for (int k = 0; k < K - 1; k++) newcol[k] = lb_q[k][c_q];
    if (clear) begin
      lb_d  = '{default: '0};
      win_d = '{default: '0};
    end else if (consume) begin
      for (int k = 0; k < K - 1; k++) lb_d[k][c_q] = newcol[k + 1];
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K - 1; kx++) win_d[ky][kx] = win_q[ky][kx + 1];
        win_d[ky][K - 1] = newcol[ky];
      end
    end
  end

  // Pipeline: products, adder tree plus bias, shift/ReLU/saturate
  always_comb begin
    p_vld_d = emit;
    prod_d  = prod_q;
    if (emit) begin
      for (int i = 0; i < KK; i++) begin
        prod_d[i] = PW'(win_d[i / K][i % K]) * PW'($signed(w_q[N * (KK - 1 - i) +: N]));
      end
    end

    s_vld_d = p_vld_q;
    sum     = bias_q;
    for (int i = 0; i < KK; i++) sum = sum + ACC_W'(prod_q[i]);
    acc_d   = p_vld_q ? sum : acc_q;

    dout_vld_d = s_vld_q;
    sh         = acc_q >>> shift_q;
    if (relu_q && sh[ACC_W-1]) sh = '0;
    dout_d = dout_q;
    if (s_vld_q) begin
      if (sh > SAT_MAX)      dout_d = N'(SAT_MAX);
      else if (sh < SAT_MIN) dout_d = N'(SAT_MIN);
      else                   dout_d = N'(sh);
    end
  end

  // State, datapath and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      r_q          <= '0;
      c_q          <= '0;
      fl_q         <= '0;
      w_q          <= '0;
      bias_q       <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      din_rdy_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      lb_q         <= '{default: '0};
      win_q        <= '{default: '0};
      p_vld_q      <= 1'b0;
      prod_q       <= '{default: '0};
      s_vld_q      <= 1'b0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      fl_q         <= fl_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      din_rdy_q    <= din_rdy_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      lb_q         <= lb_d;
      win_q        <= win_d;
      p_vld_q      <= p_vld_d;
      prod_q       <= prod_d;
      s_vld_q      <= s_vld_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
    end
  end

  assign din_rdy    = din_rdy_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed bench for conv2d_stream using three instances
// (6x6 stride 1, 4x4 padded, 6x6 stride 2) that share data and config inputs.
module tb_conv2d_stream;
  localparam int N     = 8;
  localparam int ACC_W = 32;
  localparam int KK    = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic din_vld = 1'b0;
  logic [N-1:0] din = '0;
  logic [KK*N-1:0] weight_din = '0;
  logic [ACC_W-1:0] bias_din = '0;
  logic [4:0] shift_din = '0;
  logic relu_en = 1'b0;
  logic [N-1:0] dout0, dout1, dout2;
  logic rdy0, rdy1, rdy2, vld0, vld1, vld2, busy0, busy1, busy2, done0, done1, done2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pix [64];
  int acc_cyc [64];
  int mw [KK];
  int mbias, mshift;
  bit mrelu;
  int q0[$], q1[$], q2[$], t0[$];
  int nd0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_stream #(.N(N), .INPUT_SIZE(6), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0), .ACC_W(ACC_W)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .din_vld(din_vld), .din(din), .din_rdy(rdy0),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din), .relu_en(relu_en),
    .dout(dout0), .dout_vld(vld0), .busy(busy0), .frame_done(done0));

  conv2d_stream #(.N(N), .INPUT_SIZE(4), .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .ACC_W(ACC_W)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .din_vld(din_vld), .din(din), .din_rdy(rdy1),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din), .relu_en(relu_en),
    .dout(dout1), .dout_vld(vld1), .busy(busy1), .frame_done(done1));

  conv2d_stream #(.N(N), .INPUT_SIZE(6), .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0), .ACC_W(ACC_W)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .din_vld(din_vld), .din(din), .din_rdy(rdy2),
    .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din), .relu_en(relu_en),
    .dout(dout2), .dout_vld(vld2), .busy(busy2), .frame_done(done2));

  // Output collectors, sampled on the falling edge
  always @(negedge clk) begin
    if (vld0) begin q0.push_back(int'($signed(dout0))); t0.push_back(cyc); end
    if (vld1) q1.push_back(int'($signed(dout1)));
    if (vld2) q2.push_back(int'($signed(dout2)));
    if (done0) nd0++;
  end

  function automatic bit rdy_of(input int sel);
    return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  endfunction

  function automatic bit done_of(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  // Golden convolution for one output position
  function automatic int ref_out(input int isz, input int p, input int s, input int oy, input int ox);
    longint acc;
    acc = longint'(mbias);
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++) begin
        int rr, cc;
        rr = oy * s + ky - p;
        cc = ox * s + kx - p;
        if (rr >= 0 && rr < isz && cc >= 0 && cc < isz)
          acc += longint'(pix[rr * isz + cc] * mw[ky * 3 + kx]);
      end
    acc = acc >>> mshift;
    if (mrelu && acc < 0) acc = 0;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return int'(acc);
  endfunction

  task automatic load_cfg(input int b, input int s, input bit r);
    for (int i = 0; i < KK; i++) weight_din[N * (KK - 1 - i) +: N] = N'(mw[i]);
    bias_din = ACC_W'(b);
    shift_din = 5'(s);
    relu_en = r;
    mbias = b;
    mshift = s;
    mrelu = r;
  endtask

  task automatic drive_frame(input int sel, input int npix, input bit gaps, input bit mid, output bit ok);
    int idx, guard;
    idx = 0;
    guard = 0;
    while (idx < npix && guard < 2000) begin
      @(negedge clk);
      guard++;
      start0 = 1'b0;
      if (mid && guard == 15) begin
        start0 = 1'b1;
        weight_din = '0;
        bias_din = ACC_W'(100);
      end
      din = N'(pix[idx]);
      din_vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rdy_of(sel) && din_vld) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
    end
    @(negedge clk);
    din_vld = 1'b0;
    start0 = 1'b0;
    ok = (idx == npix);
  endtask

  task automatic wait_done(input int sel, output int dcyc, output bit ok);
    int g;
    g = 0;
    ok = 1'b0;
    dcyc = -1;
    while (g < 200 && !ok) begin
      @(negedge clk);
      g++;
      if (done_of(sel)) begin ok = 1'b1; dcyc = cyc; end
    end
  endtask

  task automatic run_frame(input int sel, input int npix, input bit gaps, input bit mid, output bit ok);
    bit ok1, ok2;
    int dcyc;
    q0.delete(); q1.delete(); q2.delete(); t0.delete();
    nd0 = 0;
    @(negedge clk);
    start0 = (sel == 0);
    start1 = (sel == 1);
    start2 = (sel == 2);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    drive_frame(sel, npix, gaps, mid, ok1);
    wait_done(sel, dcyc, ok2);
    @(negedge clk);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({dout0, vld0, rdy0, busy0, done0} !== 12'h0) begin
      errors++; $display("FAIL reset_u0 got=%h exp=0", {dout0, vld0, rdy0, busy0, done0});
    end
    checks++;
    if ({dout1, vld1, rdy1, busy1, done1, dout2, vld2, rdy2, busy2, done2} !== 24'h0) begin
      errors++; $display("FAIL reset_u1u2 got=%h exp=0",
                         {dout1, vld1, rdy1, busy1, done1, dout2, vld2, rdy2, busy2, done2});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int dcyc, got;
    for (int i = 0; i < 36; i++) pix[i] = 1;
    for (int i = 0; i < KK; i++) mw[i] = 1;
    load_cfg(0, 0, 1'b0);
    q0.delete(); t0.delete();
    nd0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got=%b exp=1", busy0); end
    checks++;
    if (rdy0 !== 1'b1) begin errors++; $display("FAIL basic_rdy_rise got=%b exp=1", rdy0); end
    drive_frame(0, 36, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_drive got=%b exp=1", ok); end
    checks++;
    if (acc_cyc[35] - acc_cyc[0] !== 35) begin
      errors++; $display("FAIL basic_throughput got=%0d exp=35", acc_cyc[35] - acc_cyc[0]);
    end
    wait_done(0, dcyc, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_seen got=%b exp=1", ok); end
    checks++;
    if (dcyc !== acc_cyc[35] + 3) begin
      errors++; $display("FAIL basic_done_time got=%0d exp=%0d", dcyc, acc_cyc[35] + 3);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got=%b exp=0", busy0); end
    checks++;
    if (q0.size() !== 16) begin errors++; $display("FAIL basic_count got=%0d exp=16", q0.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < q0.size()) ? q0[i] : 9999;
      checks++;
      if (got !== 9) begin errors++; $display("FAIL basic_out[%0d] got=%0d exp=9", i, got); end
    end
    got = (t0.size() > 0) ? t0[0] : -1;
    checks++;
    if (got !== acc_cyc[14] + 3) begin
      errors++; $display("FAIL basic_latency got=%0d exp=%0d", got, acc_cyc[14] + 3);
    end
    checks++;
    if (nd0 !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", nd0); end
  endtask

  task automatic test_padding();
    bit ok;
    int dcyc, got;
    for (int i = 0; i < 16; i++) pix[i] = i + 1;
    for (int i = 0; i < KK; i++) mw[i] = (i == 4) ? 1 : 0;
    load_cfg(0, 0, 1'b0);
    q1.delete();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (rdy1 !== (i == 7)) begin
        errors++; $display("FAIL pad_rdy[%0d] got=%b exp=%b", i, rdy1, (i == 7));
      end
    end
    drive_frame(1, 16, 1'b0, 1'b0, ok);
    wait_done(1, dcyc, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL pad_done got=%b exp=1", ok); end
    @(negedge clk);
    checks++;
    if (q1.size() !== 16) begin errors++; $display("FAIL pad_count got=%0d exp=16", q1.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < q1.size()) ? q1[i] : 9999;
      checks++;
      if (got !== i + 1) begin errors++; $display("FAIL pad_out[%0d] got=%0d exp=%0d", i, got, i + 1); end
    end
  endtask

  task automatic test_stride();
    bit ok;
    int got;
    int exp_v [4];
    exp_v = '{15, 20, 42, 47};
    for (int i = 0; i < 36; i++) pix[i] = i;
    for (int i = 0; i < KK; i++) mw[i] = 1;
    load_cfg(0, 2, 1'b0);
    run_frame(2, 36, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL stride_frame got=%b exp=1", ok); end
    checks++;
    if (q2.size() !== 4) begin errors++; $display("FAIL stride_count got=%0d exp=4", q2.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < q2.size()) ? q2[i] : 9999;
      checks++;
      if (got !== exp_v[i]) begin
        errors++; $display("FAIL stride_out[%0d] got=%0d exp=%0d", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int got;
    int wv [3];
    int rv [3];
    int ev [3];
    wv = '{127, -1, -1};
    rv = '{0, 0, 1};
    ev = '{127, -128, 0};
    for (int i = 0; i < 36; i++) pix[i] = 127;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < KK; i++) mw[i] = wv[t];
      load_cfg(0, 0, rv[t] != 0);
      run_frame(0, 36, 1'b0, 1'b0, ok);
      checks++;
      if (ok !== 1'b1 || q0.size() !== 16) begin
        errors++; $display("FAIL sat_frame[%0d] got=%0d exp=16", t, q0.size());
      end
      for (int i = 0; i < 16; i++) begin
        got = (i < q0.size()) ? q0[i] : 9999;
        checks++;
        if (got !== ev[t]) begin
          errors++; $display("FAIL sat_out[%0d][%0d] got=%0d exp=%0d", t, i, got, ev[t]);
        end
      end
    end
  endtask

  task automatic test_bias_shift();
    bit ok;
    int got;
    int bv [2];
    int ev [2];
    bv = '{5, -18};
    ev = '{3, -3};
    for (int i = 0; i < 36; i++) pix[i] = 1;
    for (int i = 0; i < KK; i++) mw[i] = 1;
    for (int t = 0; t < 2; t++) begin
      load_cfg(bv[t], 2, 1'b0);
      run_frame(0, 36, 1'b0, 1'b0, ok);
      checks++;
      if (ok !== 1'b1 || q0.size() !== 16) begin
        errors++; $display("FAIL bias_frame[%0d] got=%0d exp=16", t, q0.size());
      end
      for (int i = 0; i < 16; i++) begin
        got = (i < q0.size()) ? q0[i] : 9999;
        checks++;
        if (got !== ev[t]) begin
          errors++; $display("FAIL bias_out[%0d][%0d] got=%0d exp=%0d", t, i, got, ev[t]);
        end
      end
    end
  endtask

  task automatic test_gaps_mid_start();
    bit ok;
    int got, expv;
    for (int i = 0; i < 36; i++) pix[i] = ((i * 37) % 29) - 14;
    mw = '{1, -2, 3, -1, 2, 0, 1, 1, -3};
    load_cfg(10, 1, 1'b0);
    run_frame(0, 36, 1'b1, 1'b1, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL gaps_frame got=%b exp=1", ok); end
    checks++;
    if (q0.size() !== 16) begin errors++; $display("FAIL gaps_count got=%0d exp=16", q0.size()); end
    for (int oy = 0; oy < 4; oy++)
      for (int ox = 0; ox < 4; ox++) begin
        expv = ref_out(6, 0, 1, oy, ox);
        got = (oy * 4 + ox < q0.size()) ? q0[oy * 4 + ox] : 9999;
        checks++;
        if (got !== expv) begin
          errors++; $display("FAIL gaps_out[%0d,%0d] got=%0d exp=%0d", oy, ox, got, expv);
        end
      end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int got;
    for (int i = 0; i < 36; i++) pix[i] = 1;
    for (int i = 0; i < KK; i++) mw[i] = 1;
    load_cfg(0, 0, 1'b0);
    q0.delete();
    nd0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    drive_frame(0, 20, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1 || q0.size() == 0) begin
      errors++; $display("FAIL rstmid_partial got=%0d exp=nonzero", q0.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout0, vld0, rdy0, busy0, done0} !== 12'h0) begin
      errors++; $display("FAIL rstmid_async got=%h exp=0", {dout0, vld0, rdy0, busy0, done0});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nd0 !== 0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL rstmid_abort got=%0d/%b exp=0/0", nd0, busy0);
    end
    rst_n = 1'b1;
    run_frame(0, 36, 1'b0, 1'b0, ok);
    checks++;
    if (ok !== 1'b1 || nd0 !== 1) begin
      errors++; $display("FAIL rstmid_fresh_done got=%0d exp=1", nd0);
    end
    checks++;
    if (q0.size() !== 16) begin errors++; $display("FAIL rstmid_count got=%0d exp=16", q0.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < q0.size()) ? q0[i] : 9999;
      checks++;
      if (got !== 9) begin errors++; $display("FAIL rstmid_out[%0d] got=%0d exp=9", i, got); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_stride();
    test_saturation();
    test_bias_shift();
    test_gaps_mid_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
